// File: rtl/ysyx_23060184_lsu.sv
// Load/store unit: one data-memory transaction at a time over an AXI4-Lite-style
// bus, returning formatted load data (ReadData) or an error flag to writeback.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for a request; req_ready high
// AR     | read address valid, waiting for arready
// R      | rready high, waiting for rvalid
// WR     | aw/w valids outstanding, each drops on its own handshake
// B      | bready high, waiting for bvalid
// RESP   | rsp_valid high, data/err held until rsp_ready
module ysyx_23060184_lsu #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [DATA_WIDTH-1:0] araddr,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready,
    output logic [DATA_WIDTH-1:0] awaddr,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic [3:0]            wstrb,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_WR,
        S_B,
        S_RESP
    } state_t;

    state_t state, state_nxt;

    logic                  accept;
    logic                  f3_ok;
    logic                  acc_err;
    logic                  aw_done;
    logic                  w_done;
    logic [1:0]            off_q;
    logic [2:0]            f3_q;
    logic [DATA_WIDTH-1:0] rd_shift;
    logic [DATA_WIDTH-1:0] load_fmt;
    logic [DATA_WIDTH-1:0] store_fmt;
    logic [3:0]            strb_fmt;
    logic                  unused_resp_lsb;

    // Only bit 1 of the response codes distinguishes SLVERR/DECERR from OKAY.
    assign unused_resp_lsb = ^{rresp[0], bresp[0]};

    assign req_ready = (state == S_IDLE);
    assign accept    = req_valid & req_ready;
    assign aw_done   = ~awvalid | awready;
    assign w_done    = ~wvalid | wready;

    // Decode legality and alignment of the request presented on accept.
    always_comb begin
        f3_ok = 1'b0;
        if (mem_read) begin
            f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                    (funct3 == 3'b100) || (funct3 == 3'b101);
        end else begin
            f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        end
        acc_err = (mem_read == mem_write) || !f3_ok ||
                  ((funct3[1:0] == 2'b01) && addr[0]) ||
                  ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    end

    // Store lane replication and byte strobes, computed from the live request.
    always_comb begin
        store_fmt = wdata;
        strb_fmt  = 4'b1111;
        case (funct3[1:0])
            2'b00: begin
                store_fmt = {4{wdata[7:0]}};
                strb_fmt  = 4'b0001 << addr[1:0];
            end
            2'b01: begin
                store_fmt = {2{wdata[15:0]}};
                strb_fmt  = 4'b0011 << addr[1:0];
            end
            default: begin
                store_fmt = wdata;
                strb_fmt  = 4'b1111;
            end
        endcase
    end

    // Load lane selection and sign/zero extension from the latched offset/funct3.
    always_comb begin
        rd_shift = rdata >> {off_q, 3'b000};
        load_fmt = rdata;
        case (f3_q)
            3'b000:  load_fmt = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  load_fmt = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b100:  load_fmt = {24'd0, rd_shift[7:0]};
            3'b101:  load_fmt = {16'd0, rd_shift[15:0]};
            default: load_fmt = rdata;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (acc_err)       state_nxt = S_RESP;
                    else if (mem_read) state_nxt = S_AR;
                    else               state_nxt = S_WR;
                end
            end
            S_AR:    if (arready)           state_nxt = S_R;
            S_R:     if (rvalid)            state_nxt = S_RESP;
            S_WR:    if (aw_done && w_done) state_nxt = S_B;
            S_B:     if (bvalid)            state_nxt = S_RESP;
            S_RESP:  if (rsp_ready)         state_nxt = S_IDLE;
            default:                        state_nxt = S_IDLE;
        endcase
    end

    // Registered bus valids/readies, addresses, store data and response payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            off_q     <= '0;
            f3_q      <= '0;
            araddr    <= '0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            awaddr    <= '0;
            awvalid   <= 1'b0;
            wdata_o   <= '0;
            wstrb     <= '0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        off_q     <= addr[1:0];
                        f3_q      <= funct3;
                        rsp_rdata <= '0;
                        if (acc_err) begin
                            rsp_err   <= 1'b1;
                            rsp_valid <= 1'b1;
                        end else if (mem_read) begin
                            araddr  <= {addr[DATA_WIDTH-1:2], 2'b00};
                            arvalid <= 1'b1;
                        end else begin
                            awaddr  <= {addr[DATA_WIDTH-1:2], 2'b00};
                            wdata_o <= store_fmt;
                            wstrb   <= strb_fmt;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                        end
                    end
                end
                S_AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                    end
                end
                S_R: begin
                    if (rvalid) begin
                        rready    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= rresp[1];
                        rsp_rdata <= rresp[1] ? '0 : load_fmt;
                    end
                end
                S_WR: begin
                    if (awready) awvalid <= 1'b0;
                    if (wready)  wvalid  <= 1'b0;
                    if (aw_done && w_done) bready <= 1'b1;
                end
                S_B: begin
                    if (bvalid) begin
                        bready    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= bresp[1];
                        rsp_rdata <= '0;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= '0;
                    end
                end
                default: begin
                    arvalid <= 1'b0;
                    rready  <= 1'b0;
                    awvalid <= 1'b0;
                    wvalid  <= 1'b0;
                    bready  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060184_lsu.sv
// Directed bench for the LSU with a small configurable AXI-Lite slave and a
// response scoreboard.
module tb_ysyx_23060184_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = 3'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = 2'b00;
    logic        rvalid = 1'b0;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready = 1'b0;
    logic [31:0] wdata_o;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready = 1'b0;
    logic [1:0]  bresp = 2'b00;
    logic        bvalid = 1'b0;
    logic        bready;

    // slave knobs and observations
    logic [31:0] rd_val = '0;
    logic [1:0]  rresp_val = 2'b00;
    logic [1:0]  bresp_val = 2'b00;
    logic        r_hold = 1'b0;
    int          aw_lat = 0;
    int          w_lat = 0;
    int          aw_cnt = 0;
    int          w_cnt = 0;
    logic [31:0] ar_seen = '0;
    logic [31:0] aw_seen = '0;
    logic [31:0] wd_seen = '0;
    logic [3:0]  ws_seen = '0;
    int          b_early = 0;
    int          bus_cnt = 0;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [32:0] sb_q[$];

    ysyx_23060184_lsu #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
        .addr(addr), .wdata(wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata_o(wdata_o), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    // Slave: reacts on the falling edge so the DUT samples at the next rising edge.
    always @(negedge clk) begin
        if (arvalid) begin
            arready = 1'b1;
            ar_seen = araddr;
        end else begin
            arready = 1'b0;
        end
        rvalid = rready && !r_hold;
        rdata  = rd_val;
        rresp  = rresp_val;
        if (awvalid) begin
            awready = (aw_cnt >= aw_lat);
            if (awready) aw_seen = awaddr;
            aw_cnt++;
        end else begin
            awready = 1'b0;
            aw_cnt  = 0;
        end
        if (wvalid) begin
            wready = (w_cnt >= w_lat);
            if (wready) begin
                wd_seen = wdata_o;
                ws_seen = wstrb;
            end
            w_cnt++;
        end else begin
            wready = 1'b0;
            w_cnt  = 0;
        end
        bvalid = bready;
        bresp  = bresp_val;
        if (bready && (awvalid || wvalid)) b_early++;
        if (arvalid || awvalid || wvalid) bus_cnt++;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one request for exactly one accepting cycle and record the expected response.
    task automatic issue(input logic mr, input logic mw, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_rdata, input logic exp_err);
        @(negedge clk);
        check("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        mem_read  = mr;
        mem_write = mw;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        sb_q.push_back({exp_err, exp_rdata});
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Wait for the response (cycle 1 = first cycle after accept), check it, optionally stall.
    task automatic wait_rsp(input string tag, input int exp_lat, input int hold);
        int          lat;
        logic [32:0] e;
        logic [31:0] held;
        lat = 1;
        while (!rsp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
        if (exp_lat > 0) check({tag, "_latency"}, lat, exp_lat);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({tag, "_rdata"}, rsp_rdata, e[31:0]);
            check({tag, "_err"}, {31'd0, rsp_err}, {31'd0, e[32]});
        end
        held = rsp_rdata;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_stall_valid"}, {31'd0, rsp_valid}, 32'd1);
            check({tag, "_stall_rdata"}, rsp_rdata, held);
            check({tag, "_stall_req_ready"}, {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check({tag, "_rsp_done"}, {31'd0, rsp_valid}, 32'd0);
        check({tag, "_back_idle"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        // reset values
        repeat (2) @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_valids", {27'd0, arvalid, rready, awvalid, wvalid, bready}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_araddr", araddr, 32'd0);
        check("rst_wstrb", {28'd0, wstrb}, 32'd0);
        rst_n = 1'b1;

        // LW, zero-wait
        rd_val = 32'hDEADBEEF;
        issue(1, 0, 3'b010, 32'h8000_0004, 0, 32'hDEADBEEF, 0);
        wait_rsp("lw", 3, 0);
        check("lw_araddr", ar_seen, 32'h8000_0004);

        // LB / LBU / LH / LHU extension
        rd_val = 32'h80FF7F01;
        issue(1, 0, 3'b000, 32'h8000_0003, 0, 32'hFFFFFF80, 0);
        wait_rsp("lb", 3, 0);
        check("lb_araddr", ar_seen, 32'h8000_0000);
        issue(1, 0, 3'b100, 32'h8000_0003, 0, 32'h00000080, 0);
        wait_rsp("lbu", 3, 0);
        issue(1, 0, 3'b001, 32'h8000_0002, 0, 32'hFFFF80FF, 0);
        wait_rsp("lh", 3, 0);
        issue(1, 0, 3'b101, 32'h8000_0002, 0, 32'h000080FF, 0);
        wait_rsp("lhu", 3, 0);
        issue(1, 0, 3'b000, 32'h8000_0000, 0, 32'h00000001, 0);
        wait_rsp("lb0", 3, 0);

        // SH with awready two cycles ahead of wready
        aw_lat = 0; w_lat = 2; b_early = 0;
        issue(0, 1, 3'b001, 32'h8000_0102, 32'h1234ABCD, 32'h0, 0);
        wait_rsp("sh_skew", 5, 0);
        check("sh_wdata", wd_seen, 32'hABCDABCD);
        check("sh_wstrb", {28'd0, ws_seen}, 32'h0000000C);
        check("sh_awaddr", aw_seen, 32'h8000_0100);
        check("sh_bready_early", b_early, 0);

        // SB zero-wait, and wready ahead of awready
        aw_lat = 0; w_lat = 0;
        issue(0, 1, 3'b000, 32'h8000_0001, 32'h000000A5, 32'h0, 0);
        wait_rsp("sb", 3, 0);
        check("sb_wdata", wd_seen, 32'hA5A5A5A5);
        check("sb_wstrb", {28'd0, ws_seen}, 32'h00000002);
        aw_lat = 3; w_lat = 0; b_early = 0;
        issue(0, 1, 3'b010, 32'h8000_0208, 32'hCAFEF00D, 32'h0, 0);
        wait_rsp("sw_skew", 6, 0);
        check("sw_wdata", wd_seen, 32'hCAFEF00D);
        check("sw_wstrb", {28'd0, ws_seen}, 32'h0000000F);
        check("sw_bready_early", b_early, 0);
        aw_lat = 0;

        // error paths: misaligned, illegal funct3, ambiguous op
        bus_cnt = 0;
        issue(1, 0, 3'b010, 32'h8000_0002, 0, 32'h0, 1);
        wait_rsp("lw_misal", 1, 0);
        issue(0, 1, 3'b001, 32'h8000_0011, 32'h5555, 32'h0, 1);
        wait_rsp("sh_misal", 1, 0);
        issue(1, 0, 3'b011, 32'h8000_0000, 0, 32'h0, 1);
        wait_rsp("bad_f3", 1, 0);
        issue(0, 1, 3'b100, 32'h8000_0000, 0, 32'h0, 1);
        wait_rsp("bad_store_f3", 1, 0);
        issue(1, 1, 3'b010, 32'h8000_0000, 0, 32'h0, 1);
        wait_rsp("both_ops", 1, 0);
        check("err_no_bus", bus_cnt, 0);

        // bus errors
        rresp_val = 2'b10;
        issue(1, 0, 3'b010, 32'h8000_0010, 0, 32'h0, 1);
        wait_rsp("rresp_err", 3, 0);
        rresp_val = 2'b00;
        bresp_val = 2'b11;
        issue(0, 1, 3'b010, 32'h8000_0010, 32'h1, 32'h0, 1);
        wait_rsp("bresp_err", 3, 0);
        bresp_val = 2'b00;

        // writeback backpressure
        rd_val = 32'h11223344;
        rsp_ready = 1'b0;
        issue(1, 0, 3'b010, 32'h8000_0020, 0, 32'h11223344, 0);
        wait_rsp("stall", 3, 4);

        // async reset while waiting in R
        r_hold = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0;
        funct3 = 3'b010; addr = 32'h8000_0030;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 20 && !rready; i++) @(negedge clk);
        check("rst_mid_rready_seen", {31'd0, rready}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_rready", {31'd0, rready}, 32'd0);
        check("rst_mid_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_mid_araddr", araddr, 32'd0);
        check("rst_mid_rsp", {30'd0, rsp_valid, rsp_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        r_hold = 1'b0;
        sb_q.delete();
        rd_val = 32'h0BADF00D;
        issue(1, 0, 3'b010, 32'h8000_0040, 0, 32'h0BADF00D, 0);
        wait_rsp("lw_after_rst", 3, 0);
        check("lw_after_rst_araddr", ar_seen, 32'h8000_0040);

        check("scoreboard_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
